// File: rtl/cpu_hart_ctrl_pkg.sv
// Shared types for the multi-hart boot and run-control block.
package cpu_hart_ctrl_pkg;

    typedef enum logic [1:0] {
        HART_OFF = 2'b00,
        HART_RST = 2'b01,
        HART_RUN = 2'b10
    } hart_state_e;

    function automatic int hart_idx_w(input int num_harts);
        return (num_harts > 1) ? $clog2(num_harts) : 1;
    endfunction

endpackage

// File: rtl/cpu_hart_fsm.sv
// Per-hart run-control FSM: OFF -> RST (timed hold) -> RUN, with soft reset and stop.
module cpu_hart_fsm
    import cpu_hart_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        slot_i,
    input  logic        srst_i,
    input  logic        stop_i,
    output hart_state_e state_o,
    output logic        rst_no,
    output logic        fe_o
);

    localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

    hart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_n_q, rst_n_d;
    logic             fe_q, fe_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HART_OFF;
            cnt_q   <= '0;
            rst_n_q <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            fe_q    <= fe_d;
        end
    end

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (stop_i) begin
            state_d = HART_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                HART_OFF: begin
                    if (slot_i) begin
                        state_d = HART_RST;
                        cnt_d   = CNT_LOAD;
                    end
                end
                HART_RST: begin
                    if (srst_i)             cnt_d   = CNT_LOAD;
                    else if (cnt_q == '0)   state_d = HART_RUN;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
                HART_RUN: begin
                    if (srst_i) begin
                        state_d = HART_RST;
                        cnt_d   = CNT_LOAD;
                    end
                end
                default: begin
                    state_d = HART_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Decoded from the next state so the pins move in the same cycle as state_o.
    always_comb begin
        rst_n_d = (state_d == HART_RUN);
        fe_d    = (state_d == HART_RUN);
    end

    assign state_o = state_q;
    assign rst_no  = rst_n_q;
    assign fe_o    = fe_q;

endmodule

// File: rtl/cpu_hart_ctrl.sv
// Multi-hart boot/run control: staggered start sequencer, per-hart FSMs and all-asleep filter.
module cpu_hart_ctrl
    import cpu_hart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_HARTS        = 2,
    parameter logic [31:0] BOOT_ADDR        = 32'h180,
    parameter logic [31:0] HART_BOOT_STRIDE = 32'h0,
    parameter int unsigned RST_CYCLES       = 4,
    parameter int unsigned RELEASE_GAP      = 8,
    parameter int unsigned SLEEP_FILTER     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [NUM_HARTS-1:0]    hart_en_i,
    input  logic [NUM_HARTS-1:0]    hart_srst_i,
    input  logic [NUM_HARTS-1:0]    hart_stop_i,
    input  logic [NUM_HARTS-1:0]    core_sleep_i,
    output logic [NUM_HARTS-1:0]    hart_rst_no,
    output logic [NUM_HARTS-1:0]    fetch_enable_o,
    output logic [NUM_HARTS*32-1:0] boot_addr_o,
    output logic [NUM_HARTS*32-1:0] hart_id_o,
    output logic [NUM_HARTS*2-1:0]  hart_state_o,
    output logic                    busy_o,
    output logic                    all_sleep_o
);

    localparam int unsigned IDX_W = $clog2(NUM_HARTS + 1);
    localparam int unsigned GAP_W = $clog2(RELEASE_GAP + 1);
    localparam int unsigned SLP_W = $clog2(SLEEP_FILTER + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RELEASE_GAP - 1);

    logic             busy_q, busy_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [SLP_W-1:0] slp_q, slp_d;
    logic             all_sleep_q, all_sleep_d;
    logic             fire;
    logic [IDX_W-1:0] fire_idx;
    logic [NUM_HARTS-1:0] slot;
    hart_state_e      hart_state [NUM_HARTS];
    logic             any_run, any_rst, run_awake, sleep_cond;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q      <= 1'b0;
            idx_q       <= '0;
            gap_q       <= '0;
            slp_q       <= '0;
            all_sleep_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            slp_q       <= slp_d;
            all_sleep_q <= all_sleep_d;
        end
    end

    // A slot is fired one cycle early so the hart shows RST in the slot cycle itself;
    // after the last slot the gap is zeroed so busy drops one cycle later.
    always_comb begin
        fire     = 1'b0;
        fire_idx = '0;
        busy_d   = busy_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        if (!busy_q) begin
            if (start_i) begin
                fire   = 1'b1;
                busy_d = 1'b1;
                idx_d  = IDX_W'(1);
                gap_d  = (NUM_HARTS == 1) ? '0 : GAP_LOAD;
            end
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end else if (idx_q == IDX_W'(NUM_HARTS)) begin
            busy_d = 1'b0;
            idx_d  = '0;
        end else begin
            fire     = 1'b1;
            fire_idx = idx_q;
            idx_d    = idx_q + IDX_W'(1);
            gap_d    = (idx_q == IDX_W'(NUM_HARTS - 1)) ? '0 : GAP_LOAD;
        end
    end

    for (genvar k = 0; k < NUM_HARTS; k++) begin : g_hart
        assign slot[k] = fire & (fire_idx == IDX_W'(k)) & hart_en_i[k];

        cpu_hart_fsm #(.RST_CYCLES(RST_CYCLES)) u_fsm (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .slot_i (slot[k]),
            .srst_i (hart_srst_i[k]),
            .stop_i (hart_stop_i[k]),
            .state_o(hart_state[k]),
            .rst_no (hart_rst_no[k]),
            .fe_o   (fetch_enable_o[k])
        );

        assign hart_state_o[2*k +: 2] = hart_state[k];
        assign boot_addr_o[32*k +: 32] = BOOT_ADDR + 32'(k) * HART_BOOT_STRIDE;
        assign hart_id_o[32*k +: 32]   = 32'(k);
    end

    // Asleep only counts while something runs, all runners sleep, and nothing is mid-reset.
    always_comb begin
        any_run   = 1'b0;
        any_rst   = 1'b0;
        run_awake = 1'b0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            if (hart_state[k] == HART_RUN) begin
                any_run = 1'b1;
                if (!core_sleep_i[k]) run_awake = 1'b1;
            end
            if (hart_state[k] == HART_RST) any_rst = 1'b1;
        end
        sleep_cond = any_run & ~run_awake & ~any_rst;
        if (!sleep_cond)                          slp_d = '0;
        else if (slp_q == SLP_W'(SLEEP_FILTER))   slp_d = slp_q;
        else                                      slp_d = slp_q + SLP_W'(1);
        all_sleep_d = (slp_d == SLP_W'(SLEEP_FILTER));
    end

    assign busy_o      = busy_q;
    assign all_sleep_o = all_sleep_q;

endmodule

// File: tb/tb_cpu_hart_ctrl.sv
// Scoreboard bench for cpu_hart_ctrl: stimulus queues expected values per cycle, a negedge monitor checks them.
module tb_cpu_hart_ctrl;

    localparam int NH = 2;

    typedef enum int {S_STATE, S_RSTN, S_FE, S_BUSY, S_SLEEP, S_BOOT, S_ID} sig_e;
    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [63:0] val;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start_i = 1'b0;
    logic [NH-1:0]   hart_en_i = '0;
    logic [NH-1:0]   hart_srst_i = '0;
    logic [NH-1:0]   hart_stop_i = '0;
    logic [NH-1:0]   core_sleep_i = '0;
    logic [NH-1:0]   hart_rst_no;
    logic [NH-1:0]   fetch_enable_o;
    logic [NH*32-1:0] boot_addr_o;
    logic [NH*32-1:0] hart_id_o;
    logic [NH*2-1:0] hart_state_o;
    logic            busy_o;
    logic            all_sleep_o;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb_q[$];

    cpu_hart_ctrl #(
        .NUM_HARTS       (NH),
        .BOOT_ADDR       (32'h180),
        .HART_BOOT_STRIDE(32'h1000),
        .RST_CYCLES      (4),
        .RELEASE_GAP     (8),
        .SLEEP_FILTER    (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .hart_en_i     (hart_en_i),
        .hart_srst_i   (hart_srst_i),
        .hart_stop_i   (hart_stop_i),
        .core_sleep_i  (core_sleep_i),
        .hart_rst_no   (hart_rst_no),
        .fetch_enable_o(fetch_enable_o),
        .boot_addr_o   (boot_addr_o),
        .hart_id_o     (hart_id_o),
        .hart_state_o  (hart_state_o),
        .busy_o        (busy_o),
        .all_sleep_o   (all_sleep_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [63:0] sample(input sig_e s);
        case (s)
            S_STATE: return 64'(hart_state_o);
            S_RSTN:  return 64'(hart_rst_no);
            S_FE:    return 64'(fetch_enable_o);
            S_BUSY:  return 64'(busy_o);
            S_SLEEP: return 64'(all_sleep_o);
            S_BOOT:  return 64'(boot_addr_o);
            default: return 64'(hart_id_o);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Monitor: every negedge, compare and retire all expectations due this cycle.
    always @(negedge clk_i) begin
        int          i;
        logic [63:0] act;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].cyc == cyc) begin
                act = sample(sb_q[i].sig);
                n_checks++;
                if (act === sb_q[i].val) n_pass++;
                else $display("FAIL %s @cycle %0d: got %0h expected %0h",
                              sb_q[i].sig.name(), cyc, act, sb_q[i].val);
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expect_at(input int c, input sig_e s, input logic [63:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        // Reset state and constant outputs
        expect_at(1, S_STATE, 64'h0);
        expect_at(1, S_RSTN,  64'h0);
        expect_at(1, S_FE,    64'h0);
        expect_at(1, S_BUSY,  64'h0);
        expect_at(1, S_SLEEP, 64'h0);
        expect_at(3, S_BOOT,  {32'h0000_1180, 32'h0000_0180});
        expect_at(3, S_ID,    {32'd1, 32'd0});
        expect_at(3, S_STATE, 64'h0);
        wait_cyc(2);
        rst_ni = 1'b1;
        check("boot_addr[0]", 64'(boot_addr_o[31:0]),  64'h180);
        check("boot_addr[1]", 64'(boot_addr_o[63:32]), 64'h1180);
        check("hart_id[0]",   64'(hart_id_o[31:0]),    64'd0);
        check("hart_id[1]",   64'(hart_id_o[63:32]),   64'd1);

        // Staggered start, both harts enabled
        wait_cyc(10);
        expect_at(11, S_STATE, 64'b0001);
        expect_at(11, S_BUSY,  64'h1);
        expect_at(14, S_STATE, 64'b0001);
        expect_at(14, S_FE,    64'b00);
        expect_at(15, S_STATE, 64'b0010);
        expect_at(15, S_FE,    64'b01);
        expect_at(15, S_RSTN,  64'b01);
        expect_at(18, S_STATE, 64'b0010);
        expect_at(19, S_STATE, 64'b0110);
        expect_at(19, S_BUSY,  64'h1);
        expect_at(20, S_BUSY,  64'h0);
        expect_at(22, S_STATE, 64'b0110);
        expect_at(23, S_STATE, 64'b1010);
        expect_at(23, S_FE,    64'b11);
        expect_at(23, S_RSTN,  64'b11);
        hart_en_i = 2'b11;
        start_i   = 1'b1;
        wait_cyc(11);
        start_i   = 1'b0;

        // Soft reset of hart0 from RUN
        wait_cyc(30);
        expect_at(31, S_STATE, 64'b1001);
        expect_at(31, S_FE,    64'b10);
        expect_at(34, S_STATE, 64'b1001);
        expect_at(34, S_RSTN,  64'b10);
        expect_at(35, S_STATE, 64'b1010);
        expect_at(35, S_FE,    64'b11);
        hart_srst_i = 2'b01;
        wait_cyc(31);
        hart_srst_i = 2'b00;

        // Sleep filter: assert after 16 qualifying cycles, drop the cycle after C falls
        wait_cyc(40);
        expect_at(55, S_SLEEP, 64'h0);
        expect_at(56, S_SLEEP, 64'h1);
        expect_at(60, S_SLEEP, 64'h1);
        expect_at(61, S_SLEEP, 64'h0);
        core_sleep_i = 2'b11;
        wait_cyc(60);
        core_sleep_i = 2'b01;
        wait_cyc(61);
        core_sleep_i = 2'b11;

        // Hold hart1 in RST via repeated srst: sleep must never assert
        wait_cyc(70);
        expect_at(80,  S_SLEEP, 64'h0);
        expect_at(80,  S_STATE, 64'b0110);
        expect_at(100, S_SLEEP, 64'h0);
        expect_at(103, S_STATE, 64'b0110);
        expect_at(104, S_STATE, 64'b1010);
        expect_at(119, S_SLEEP, 64'h0);
        expect_at(120, S_SLEEP, 64'h1);
        hart_srst_i = 2'b10;
        wait_cyc(100);
        hart_srst_i = 2'b00;

        // Stop beats srst; sleep tracks only running harts
        wait_cyc(130);
        expect_at(131, S_STATE, 64'b1000);
        expect_at(131, S_FE,    64'b10);
        expect_at(131, S_RSTN,  64'b10);
        expect_at(132, S_SLEEP, 64'h1);
        expect_at(136, S_STATE, 64'b0000);
        expect_at(136, S_SLEEP, 64'h1);
        expect_at(137, S_SLEEP, 64'h0);
        hart_srst_i = 2'b01;
        hart_stop_i = 2'b01;
        wait_cyc(131);
        hart_srst_i = 2'b00;
        hart_stop_i = 2'b00;
        wait_cyc(135);
        hart_stop_i = 2'b10;
        wait_cyc(136);
        hart_stop_i = 2'b00;
        core_sleep_i = 2'b00;

        // Only hart1 enabled; second start while busy is ignored
        wait_cyc(150);
        expect_at(151, S_STATE, 64'b0000);
        expect_at(151, S_BUSY,  64'h1);
        expect_at(151, S_RSTN,  64'b00);
        expect_at(155, S_STATE, 64'b0000);
        expect_at(155, S_RSTN,  64'b00);
        expect_at(158, S_STATE, 64'b0000);
        expect_at(159, S_STATE, 64'b0100);
        expect_at(159, S_BUSY,  64'h1);
        expect_at(160, S_BUSY,  64'h0);
        expect_at(163, S_STATE, 64'b1000);
        expect_at(163, S_FE,    64'b10);
        expect_at(163, S_RSTN,  64'b10);
        expect_at(164, S_BUSY,  64'h0);
        hart_en_i = 2'b10;
        start_i   = 1'b1;
        wait_cyc(151);
        start_i   = 1'b0;
        wait_cyc(154);
        start_i   = 1'b1;
        wait_cyc(155);
        start_i   = 1'b0;

        // Stop beats a coinciding slot, then async reset at slot 1
        wait_cyc(170);
        expect_at(171, S_STATE, 64'b0000);
        expect_at(181, S_STATE, 64'b0000);
        expect_at(181, S_BUSY,  64'h1);
        expect_at(188, S_STATE, 64'b0000);
        expect_at(189, S_STATE, 64'b0000);
        expect_at(189, S_RSTN,  64'b00);
        expect_at(189, S_FE,    64'b00);
        expect_at(189, S_BUSY,  64'h0);
        expect_at(189, S_SLEEP, 64'h0);
        expect_at(200, S_STATE, 64'b0000);
        expect_at(200, S_BUSY,  64'h0);
        expect_at(205, S_STATE, 64'b0000);
        expect_at(205, S_RSTN,  64'b00);
        hart_stop_i = 2'b10;
        wait_cyc(171);
        hart_stop_i = 2'b00;
        wait_cyc(180);
        hart_en_i   = 2'b11;
        start_i     = 1'b1;
        hart_stop_i = 2'b01;
        wait_cyc(181);
        start_i     = 1'b0;
        hart_stop_i = 2'b00;
        wait_cyc(189);
        rst_ni = 1'b0;
        wait_cyc(191);
        rst_ni = 1'b1;

        wait_cyc(210);
        check("hart_state_o",   64'(hart_state_o),   64'h0);
        check("hart_rst_no",    64'(hart_rst_no),    64'h0);
        check("fetch_enable_o", 64'(fetch_enable_o), 64'h0);
        check("busy_o",         64'(busy_o),         64'h0);
        check("all_sleep_o",    64'(all_sleep_o),    64'h0);
        foreach (sb_q[i]) begin
            n_checks++;
            $display("FAIL %s @cycle %0d: never checked, expected %0h",
                     sb_q[i].sig.name(), sb_q[i].cyc, sb_q[i].val);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_hart_ctrl.md
Name: cpu_hart_ctrl

Overview:
Multi-hart boot and run-control block that sits between the always-on control logic and N CPU cores in the CPU subsystem. It replaces hard-wired fetch_enable=1 and a single hart with per-hart reset and fetch-enable sequencing. It releases harts in a staggered order, handles per-hart soft reset and stop, and produces a debounced all-harts-asleep indication for the power manager.

Parameters:
NUM_HARTS, 2, number of controlled cores (1..8)
BOOT_ADDR, 'h180, boot address of hart 0
HART_BOOT_STRIDE, 'h0, boot address increment per hart index
RST_CYCLES, 4, cycles a hart's reset is held low on entry to RST (>=1)
RELEASE_GAP, 8, cycles between consecutive hart slots during a start sequence (>=1)
SLEEP_FILTER, 16, consecutive qualifying cycles before all_sleep_o asserts (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  pulse; begins staggered release of enabled harts
hart_en_i  in  NUM_HARTS  harts selected for release by start_i
hart_srst_i  in  NUM_HARTS  per-hart soft-reset request pulse
hart_stop_i  in  NUM_HARTS  per-hart stop request pulse
core_sleep_i  in  NUM_HARTS  core_sleep_o of each core
hart_rst_no  out  NUM_HARTS  per-hart active-low core reset, registered
fetch_enable_o  out  NUM_HARTS  per-hart fetch enable, registered
boot_addr_o  out  NUM_HARTS*32  constant BOOT_ADDR + k*HART_BOOT_STRIDE for hart k
hart_id_o  out  NUM_HARTS*32  constant k for hart k
hart_state_o  out  NUM_HARTS*2  per-hart FSM state encoding
busy_o  out  1  start sequencer active
all_sleep_o  out  1  debounced all-running-harts-asleep

Behaviour:
- Reset (async, rst_ni=0): all harts OFF; hart_rst_no=0, fetch_enable_o=0, busy_o=0, all_sleep_o=0; all counters 0.
- Per-hart FSM, encoding OFF=00, RST=01, RUN=10 (11 unused, maps to OFF).
  - OFF: rst_n=0, fe=0.
  - RST: rst_n=0, fe=0; counter loads RST_CYCLES-1 on entry and moves to RUN when it reaches 0. The hart spends exactly RST_CYCLES cycles in RST.
  - RUN: rst_n=1, fe=1.
- Outputs are registered from the next state, so they change in the same cycle hart_state_o changes.
- Sequencer:
  - start_i sampled high with busy_o=0 at cycle t sets busy_o=1 from t+1. start_i while busy_o=1 is ignored.
  - Slot k occurs at cycle t+1+k*RELEASE_GAP, for k=0..NUM_HARTS-1.
  - At slot k, hart k moves OFF->RST if hart_en_i[k]=1 at that cycle. Harts already in RST or RUN are unaffected.
  - busy_o drops in the cycle after slot NUM_HARTS-1.
- Soft reset: hart_srst_i[k] in RUN -> RST (full RST_CYCLES count), then RUN. In RST it restarts the count. In OFF it is ignored.
- Stop: hart_stop_i[k] in any state -> OFF next cycle. Stop has priority over srst and over a coinciding slot.
- Slot entry and srst for the same hart in the same cycle: the hart enters RST once (single count).
- Sleep condition C:
  - C = (at least one hart in RUN) AND (every RUN hart has core_sleep_i=1) AND (no hart in RST).
  - A saturating counter increments while C=1 and clears to 0 when C=0.
  - all_sleep_o=1 from the cycle after C has held SLEEP_FILTER consecutive sampled cycles.
  - all_sleep_o=0 in the cycle after C drops.
- Width rules: counters sized with $clog2(param+1). boot_addr_o arithmetic is 32-bit with wrap-around.

Decomposition:
- Shared package cpu_hart_ctrl_pkg:
  - hart_state_e enum (OFF/RST/RUN, 2-bit)
  - HART_IDX_W = $clog2(NUM_HARTS) helper function
- One sub-module, cpu_hart_fsm: per-hart FSM plus RST counter, instantiated NUM_HARTS times in a generate loop.
- Sequencer and sleep filter stay in the top.

Test Plan:
- Reset, then NUM_HARTS=2, en=11, RST_CYCLES=4, GAP=8, start at t=10 -> hart0 RST at 11 and RUN at 15; hart1 RST at 19 and RUN at 23; busy_o high 11..19, low at 20.
- en=10 -> hart0 stays OFF with hart_rst_no[0]=0; hart1 RUN at 23. A second start_i at t=14 is ignored, so hart1's timing is unchanged.
- Hart0 in RUN, srst pulse at 30 -> state RST at 31..34 with fe=0, RUN at 35. srst at 40 together with stop at 40 -> OFF at 41.
- Both harts RUN with core_sleep_i=11 from 50, SLEEP_FILTER=16 -> all_sleep_o=1 at 66. core_sleep_i[1]=0 at 70 -> all_sleep_o=0 at 71. Repeat with one hart in RST -> all_sleep_o never asserts.
- Assert rst_ni=0 mid-sequence at slot 1 -> all outputs 0 immediately. After release, no hart moves until a new start_i.
- Check boot_addr_o with HART_BOOT_STRIDE='h1000 -> hart1 boot_addr_o='h1180.
